// File: rtl/alu.sv
// rtl/alu.sv - single-cycle registered ALU with RV32I-style operation decode
module alu (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_data_1,
    input  logic [31:0] i_data_2,
    input  logic [3:0]  i_mode,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_zero
);

    logic [31:0] result_d;
    logic [31:0] data_q;
    logic        zero_q;
    logic        valid_q;
    logic [4:0]  shamt;

    assign shamt = i_data_2[4:0];

    always_comb begin
        result_d = 32'h0000_0000;
        unique case (i_mode[3:1])
            3'b000: result_d = i_mode[0] ? (i_data_1 - i_data_2) : (i_data_1 + i_data_2);
            3'b001: result_d = i_data_1 << shamt;
            3'b010: result_d = {31'b0, $signed(i_data_1) < $signed(i_data_2)};
            3'b011: result_d = {31'b0, i_data_1 < i_data_2};
            3'b100: result_d = i_data_1 ^ i_data_2;
            3'b101: result_d = i_mode[0] ? 32'($signed(i_data_1) >>> shamt) : (i_data_1 >> shamt);
            3'b110: result_d = i_data_1 | i_data_2;
            3'b111: result_d = i_data_1 & i_data_2;
            default: result_d = 32'h0000_0000;
        endcase
    end

    // Zero flag is derived from the same value captured into data_q.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q  <= 32'h0000_0000;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            valid_q <= i_valid;
            if (i_valid) begin
                data_q <= result_d;
                zero_q <= (result_d == 32'h0000_0000);
            end
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_zero  = zero_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - randomized model-checked bench for alu
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic [3:0]  mode = 4'h0;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_zero;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_data;
    logic        m_zero;
    logic        m_valid;

    alu dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid),
        .i_data_1 (a),
        .i_data_2 (b),
        .i_mode   (mode),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_zero   (o_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [31:0] x, input logic [31:0] y, input logic [3:0] m);
        int unsigned sh;
        logic [31:0] fill;
        sh = y % 32;
        case (m / 2)
            0: return (m % 2) ? x - y : x + y;
            1: return x << sh;
            2: return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            3: return (x < y) ? 32'd1 : 32'd0;
            4: return x ^ y;
            5: begin
                fill = (m % 2 && x[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
                return (x >> sh) | fill;
            end
            6: return x | y;
            default: return x & y;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge rst_n) begin
        m_data  = 32'h0;
        m_zero  = 1'b1;
        m_valid = 1'b0;
    end

    // Model update on every edge, then compare shortly after.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_data  = 32'h0;
            m_zero  = 1'b1;
            m_valid = 1'b0;
        end else begin
            m_valid = valid;
            if (valid) begin
                m_data = ref_op(a, b, mode);
                m_zero = (m_data == 32'h0);
            end
        end
        #1;
        if (chk_en) begin
            chk("model_valid", {31'b0, o_valid}, {31'b0, m_valid});
            chk("model_data", o_data, m_data);
            chk("model_zero", {31'b0, o_zero}, {31'b0, m_zero});
        end
    end

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [3:0] m);
        @(negedge clk);
        valid = v;
        a = x;
        b = y;
        mode = m;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] sweep_exp [16];
    logic [31:0] held;

    initial begin
        sweep_exp = '{32'hFFFFFF03, 32'hFFFFFEFF, 32'hFFFFFC04, 32'hFFFFFC04,
                      32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000,
                      32'hFFFFFF03, 32'hFFFFFF03, 32'h3FFFFFC0, 32'hFFFFFFC0,
                      32'hFFFFFF03, 32'hFFFFFF03, 32'h00000000, 32'h00000000};

        #2 rst_n = 1'b0;
        #1;
        chk("reset_data", o_data, 32'h0);
        chk("reset_zero", {31'b0, o_zero}, 32'd1);
        chk("reset_valid", {31'b0, o_valid}, 32'd0);
        chk_en = 1'b1;

        drive(1'b1, 32'h1234_5678, 32'h1, 4'h0);
        after_edge();
        chk("reset_hold_data", o_data, 32'h0);
        chk("reset_hold_valid", {31'b0, o_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        after_edge();
        chk("first_edge", o_data, 32'h1234_5679);

        for (int m = 0; m < 16; m++) begin
            drive(1'b1, 32'hFFFF_FF01, 32'h2, 4'(m));
            after_edge();
            chk($sformatf("sweep_mode%0d", m), o_data, sweep_exp[m]);
            chk($sformatf("sweep_valid%0d", m), {31'b0, o_valid}, 32'd1);
        end
        chk("sweep_and_zero", {31'b0, o_zero}, 32'd1);

        drive(1'b1, 32'h1, 32'h21, 4'b0010);
        after_edge();
        chk("shift_mask", o_data, 32'h2);

        drive(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 4'b0100);
        after_edge();
        chk("slt_extreme", o_data, 32'h1);
        drive(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 4'b0110);
        after_edge();
        chk("sltu_extreme", o_data, 32'h0);

        drive(1'b1, 32'hFFFF_FFFF, 32'h1, 4'b0000);
        after_edge();
        chk("add_wrap", o_data, 32'h0);
        chk("add_wrap_zero", {31'b0, o_zero}, 32'd1);
        drive(1'b1, 32'h0, 32'h1, 4'b0001);
        after_edge();
        chk("sub_wrap", o_data, 32'hFFFF_FFFF);
        chk("sub_wrap_zero", {31'b0, o_zero}, 32'd0);

        drive(1'b1, 32'hDEAD_BEEF, 32'h0, 4'b1011);
        after_edge();
        chk("sra_by0", o_data, 32'hDEAD_BEEF);
        held = o_data;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, $urandom, $urandom, 4'($urandom));
            after_edge();
            chk("hold_data", o_data, 32'hDEAD_BEEF);
            chk("hold_valid", {31'b0, o_valid}, 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: x = 32'h8000_0000;
                1: y = {$urandom_range(0, 7) == 0 ? 27'h0 : 27'($urandom), 5'($urandom_range(0, 31))};
                2: y = x;
                3: x = 32'hFFFF_FFFF;
                default: ;
            endcase
            drive(($urandom_range(0, 3) != 0), x, y, 4'($urandom));
        end

        drive(1'b1, 32'h0000_0100, 32'h4, 4'b1010);
        after_edge();
        chk("srl_pre_reset", o_data, 32'h10);
        #1 rst_n = 1'b0;
        #1;
        chk("async_data", o_data, 32'h0);
        chk("async_zero", {31'b0, o_zero}, 32'd1);
        chk("async_valid", {31'b0, o_valid}, 32'd0);
        drive(1'b1, 32'h5, 32'h5, 4'b0000);
        rst_n = 1'b1;
        after_edge();
        chk("post_reset_add", o_data, 32'hA);

        drive(1'b0, 32'h0, 32'h0, 4'h0);
        after_edge();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
